cpu_clock_gen: RTL and testbench
================================

# cpu_clock_gen

Clock-enable generator for the 8-bit computer core. It sits directly downstream of the button and DIP pull-down emulation in the top level. It debounces the step and mode buttons and runs a small run/step/halt state machine. Its output is a single-cycle clock-enable pulse that advances the CPU registers, ALU and control logic, all of which run on the 100 MHz board clock. It mirrors the Ben Eater astable/monostable clock module without deriving a separate clock.

## Interface

- CLK_HZ, 100_000_000, board clock frequency; informational only.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required to accept a button level change (10 ms).
- BASE_DIV, 1_562_500, base period in clk cycles of the fastest run rate (64 Hz).
- DIV_WIDTH, 27, width of the run-rate divider counter; must hold BASE_DIV*64-1.

Ports:

- clk  input  1  100 MHz board clock.
- rst_n  input  1  reset, asynchronous, active-low.
- step_btn  input  1  raw step button after pull-down emulation, asynchronous.
- mode_btn  input  1  raw run/step toggle button after pull-down emulation, asynchronous.
- halt  input  1  CPU HLT control line, synchronous to clk, level.
- rate_sel  input  2  run rate select from DIP switches; quasi-static, sampled every cycle.
- cpu_clk_en  output  1  one-cycle CPU advance pulse.
- cpu_clk_led  output  1  toggles on every cpu_clk_en pulse, for the clock LED.
- running  output  1  high in RUN.
- halted  output  1  high in HALTED.

## Operation

- Each button passes through a 2-FF synchronizer and then a debouncer.
  - The debouncer holds a stable level.
  - A counter increments while the synchronized input differs from the stable level and clears when the two match.
  - On reaching DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- A rising edge of a stable level produces a one-cycle event: step_ev or mode_ev. Falling edges produce nothing.
- FSM states, reset state STEP:
  - STEP: step_ev produces one cpu_clk_en pulse. mode_ev moves to RUN. If step_ev and mode_ev occur together, mode wins: go to RUN, no pulse.
  - RUN: the divider counts. When the count is at least period-1, cpu_clk_en pulses and the count wraps to 0. step_ev is ignored. mode_ev moves to STEP and clears the divider.
  - HALTED: cpu_clk_en is held 0 and all events are ignored. Only rst_n exits this state.
- halt=1 in STEP or RUN moves to HALTED. halt has priority over every event in the same cycle, and no pulse is issued in that cycle.
- Run period in cycles = BASE_DIV << (2*(3-rate_sel)):
  - rate_sel=3 gives 64 Hz.
  - rate_sel=2 gives 16 Hz.
  - rate_sel=1 gives 4 Hz.
  - rate_sel=0 gives 1 Hz.
- The period compare is evaluated every cycle. If rate_sel shrinks the period below the current count, a pulse fires on the next cycle and the count wraps.
- Entering RUN clears the divider, so the first pulse occurs one full period after entry.
- Reset values: cpu_clk_en=0, cpu_clk_led=0, running=0, halted=0, FSM=STEP, divider=0, synchronizers=0, stable levels=0, debounce counters=0.
- Reset asserted mid-operation clears all state immediately, asynchronously. Any pulse in flight is lost.

## Timing

- All outputs are registered.
- Button to pulse, in STEP: cpu_clk_en is high exactly D+3 clk cycles after the first rising edge at which the raw input is high and stays high.
  - D = DEBOUNCE_CYCLES.
  - The 3 cycles are 2 synchronizer stages plus 1 event/pulse register.
- Bounce shorter than D cycles produces no event.
- halt to halted: halted=1 one cycle after halt is sampled high.
- cpu_clk_en is never high on two consecutive cycles, provided BASE_DIV≥2.
- cpu_clk_led changes in the same cycle cpu_clk_en is high.

## Configuration

- CPU_CLOCK_DEBOUNCE_EN defined: debouncers are instantiated as described above.
- CPU_CLOCK_DEBOUNCE_EN undefined: debouncers are removed, and the stable level equals the synchronizer output (D=0, latency 3 cycles). This is intended for fast simulation and switch-free builds.

## Test plan

- Reset, then a 1 µs step_btn press with DEBOUNCE_CYCLES=4 -> exactly one cpu_clk_en pulse, 7 cycles after the press is sampled; cpu_clk_led goes 0->1.
- step_btn toggling every 2 cycles for 20 cycles, then stable high, with D=4 -> exactly one pulse, D+3 cycles after the final rising edge.
- mode press, BASE_DIV=8, rate_sel=3 -> running=1; pulses every 8 cycles, first one 8 cycles after entry; step presses ignored; rate_sel=2 -> pulses every 32 cycles.
- In RUN with the count at 20, rate_sel changes 2->3 -> a pulse on the next cycle, then every 8 cycles.
- halt=1 in the same cycle as a due divider pulse -> no pulse; halted=1 next cycle; further step/mode presses give no pulse; rst_n low -> STEP with all outputs 0.
- step_ev and mode_ev in the same cycle in STEP -> running=1 and no pulse in that cycle.

Source files
------------

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: button debounce plus run/step/halt control that produces a
// one-cycle CPU advance enable on the board clock.
// Build option: CPU_CLOCK_DEBOUNCE_EN keeps the button debouncers; without it
// the debounced level is taken straight from the synchronizer.
module cpu_clock_gen #(
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BASE_DIV        = 1_562_500,
    parameter int unsigned DIV_WIDTH       = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_btn,
    input  logic       mode_btn,
    input  logic       halt,
    input  logic [1:0] rate_sel,
    output logic       cpu_clk_en,
    output logic       cpu_clk_led,
    output logic       running,
    output logic       halted
);

    localparam logic [DIV_WIDTH-1:0] PER_M1_64HZ = DIV_WIDTH'(BASE_DIV - 1);
    localparam logic [DIV_WIDTH-1:0] PER_M1_16HZ = DIV_WIDTH'(BASE_DIV * 4 - 1);
    localparam logic [DIV_WIDTH-1:0] PER_M1_4HZ  = DIV_WIDTH'(BASE_DIV * 16 - 1);
    localparam logic [DIV_WIDTH-1:0] PER_M1_1HZ  = DIV_WIDTH'(BASE_DIV * 64 - 1);

    typedef enum logic [1:0] {
        ST_STEP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Bit 0 is the step button, bit 1 the mode button.
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic       step_ev;
    logic       mode_ev;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic [DIV_WIDTH-1:0] period_m1;
    logic                 pulse_nxt;

    // CLK_HZ is documentation only; DEBOUNCE_CYCLES is unused without debouncers.
    logic unused_params;
    assign unused_params = ^{32'(CLK_HZ), 32'(DEBOUNCE_CYCLES)};

    assign btn_raw = {mode_btn, step_btn};

    // Two-stage synchronizer for both asynchronous buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef CPU_CLOCK_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt [2];

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign stable = sync2;
`endif

    // Previous stable level, for rising-edge event detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign step_ev = stable[0] & ~stable_d[0];
    assign mode_ev = stable[1] & ~stable_d[1];

    // Run period (minus one) selected by the DIP switches.
    always_comb begin
        period_m1 = PER_M1_1HZ;
        case (rate_sel)
            2'd3:    period_m1 = PER_M1_64HZ;
            2'd2:    period_m1 = PER_M1_16HZ;
            2'd1:    period_m1 = PER_M1_4HZ;
            default: period_m1 = PER_M1_1HZ;
        endcase
    end

    // State, divider and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_STEP;
            div_cnt     <= '0;
            cpu_clk_en  <= 1'b0;
            cpu_clk_led <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            cpu_clk_en  <= pulse_nxt;
            cpu_clk_led <= cpu_clk_led ^ pulse_nxt;
            running     <= (state_nxt == ST_RUN);
            halted      <= (state_nxt == ST_HALTED);
        end
    end

    // Next state: halt beats mode, mode beats step or a due divider pulse.
    always_comb begin
        state_nxt = state;
        div_nxt   = '0;
        pulse_nxt = 1'b0;
        case (state)
            ST_STEP: begin
                if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (mode_ev) begin
                    state_nxt = ST_RUN;
                end else if (step_ev) begin
                    pulse_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_HALTED;
                end else if (mode_ev) begin
                    state_nxt = ST_STEP;
                end else if (div_cnt >= period_m1) begin
                    pulse_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt + DIV_WIDTH'(1);
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_STEP;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: directed scenarios plus random button/halt/rate activity,
// all compared each cycle against a behavioural model of the clock module.
module tb_cpu_clock_gen;

    localparam int unsigned DB_CYC = 4;
    localparam int unsigned BASE   = 8;
    localparam int unsigned DIVW   = 12;
`ifdef CPU_CLOCK_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    localparam int S_STEP = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic       clk;
    logic       rst_n;
    logic       step_btn;
    logic       mode_btn;
    logic       halt;
    logic [1:0] rate_sel;
    logic       cpu_clk_en;
    logic       cpu_clk_led;
    logic       running;
    logic       halted;

    int total = 0;
    int bad   = 0;

    // Model state
    bit m_r1 [2];
    bit m_r2 [2];
    bit m_stab [2];
    bit m_prev [2];
    int m_cnt [2];
    int m_state;
    int m_last;
    int cyc;
    bit m_en;
    bit m_led;

    cpu_clock_gen #(
        .CLK_HZ(100_000_000),
        .DEBOUNCE_CYCLES(DB_CYC),
        .BASE_DIV(BASE),
        .DIV_WIDTH(DIVW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .step_btn(step_btn),
        .mode_btn(mode_btn),
        .halt(halt),
        .rate_sel(rate_sel),
        .cpu_clk_en(cpu_clk_en),
        .cpu_clk_led(cpu_clk_led),
        .running(running),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int run_period(input int rate);
        int p;
        p = BASE;
        for (int k = rate; k < 3; k++) p = p * 4;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_r1[i] = 0; m_r2[i] = 0; m_stab[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
        end
        m_state = S_STEP;
        m_en    = 0;
        m_led   = 0;
    endtask

    // One board-clock edge of the reference behaviour, using inputs present at the edge.
    task automatic model_step();
        bit raw [2];
        bit ev [2];
        bit syn;
        bit st;
        bit pulse;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw[0] = step_btn;
        raw[1] = mode_btn;
        for (int i = 0; i < 2; i++) begin
            syn     = m_r2[i];
            m_r2[i] = m_r1[i];
            m_r1[i] = raw[i];
`ifdef CPU_CLOCK_DEBOUNCE_EN
            st = m_stab[i];
            if (syn != m_stab[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == D) begin
                    m_stab[i] = syn;
                    m_cnt[i]  = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
`else
            st = syn;
`endif
            ev[i]     = st & ~m_prev[i];
            m_prev[i] = st;
        end
        pulse = 0;
        if (m_state == S_STEP) begin
            if (halt) m_state = S_HALT;
            else if (ev[1]) begin
                m_state = S_RUN;
                m_last  = cyc;
            end else if (ev[0]) pulse = 1;
        end else if (m_state == S_RUN) begin
            if (halt) m_state = S_HALT;
            else if (ev[1]) m_state = S_STEP;
            else if (cyc - m_last >= run_period(int'(rate_sel))) begin
                pulse  = 1;
                m_last = cyc;
            end
        end
        m_en  = pulse;
        m_led = m_led ^ pulse;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("en", int'(cpu_clk_en), int'(m_en));
        check_val("led", int'(cpu_clk_led), int'(m_led));
        check_val("running", int'(running), int'(m_state == S_RUN));
        check_val("halted", int'(halted), int'(m_state == S_HALT));
    endtask

    // Assert reset away from the clock edge and confirm it takes effect at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async_en", int'(cpu_clk_en), 0);
        check_val("rst_async_led", int'(cpu_clk_led), 0);
        check_val("rst_async_run", int'(running), 0);
        check_val("rst_async_halt", int'(halted), 0);
        model_reset();
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_clk_en && n < 600);
    endtask

    task automatic wait_running(input string tag);
        int n;
        n = 0;
        while (!running && n < 40) begin
            tick();
            n++;
        end
        check_val(tag, int'(running), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int np;
        int hold_cnt;
        cyc      = 0;
        m_last   = 0;
        step_btn = 1'b0;
        mode_btn = 1'b0;
        halt     = 1'b0;
        rate_sel = 2'd3;
        rst_n    = 1'b0;
        model_reset();
        repeat (3) tick();
        check_val("reset_en", int'(cpu_clk_en), 0);
        check_val("reset_led", int'(cpu_clk_led), 0);
        check_val("reset_running", int'(running), 0);
        check_val("reset_halted", int'(halted), 0);
        #2;
        rst_n = 1'b1;
        repeat (3) tick();

        // Single step press: pulse in the (D+3)th cycle counting the sampling edge.
        step_btn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_clk_en && n < 40);
        check_val("step_latency", n, D + 3);
        check_val("step_led", int'(cpu_clk_led), 1);
        repeat (D + 6) tick();
        step_btn = 1'b0;
        repeat (D + 6) tick();

        // Bouncing press, then a clean press.
        np = 0;
        for (int i = 0; i < 10; i++) begin
            step_btn = ~step_btn;
            repeat (2) begin
                tick();
                if (cpu_clk_en) np++;
            end
        end
        check_val("bounce_pulses", np, (D == 0) ? 5 : 0);
        step_btn = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_clk_en && n < 40);
        check_val("bounce_latency", n, D + 3);
        repeat (D + 6) tick();
        step_btn = 1'b0;
        repeat (D + 6) tick();

        // Enter RUN at the fastest rate; step presses are ignored.
        mode_btn = 1'b1;
        wait_running("run_enter");
        mode_btn = 1'b0;
        step_btn = 1'b1;
        wait_pulse(n);
        check_val("run_first", n, 8);
        step_btn = 1'b0;
        wait_pulse(n);
        check_val("run_period3", n, 8);
        rate_sel = 2'd2;
        wait_pulse(n);
        wait_pulse(n);
        check_val("run_period2", n, 32);

        // Shrinking the period below the running count fires on the next edge.
        repeat (20) tick();
        rate_sel = 2'd3;
        tick();
        check_val("rate_shrink", int'(cpu_clk_en), 1);
        wait_pulse(n);
        check_val("after_shrink", n, 8);

        // Halt on the very edge a divider pulse is due.
        repeat (7) tick();
        halt = 1'b1;
        tick();
        check_val("halt_nopulse", int'(cpu_clk_en), 0);
        check_val("halt_flag", int'(halted), 1);
        halt = 1'b0;
        np = 0;
        step_btn = 1'b1;
        repeat (D + 6) begin tick(); if (cpu_clk_en) np++; end
        step_btn = 1'b0;
        mode_btn = 1'b1;
        repeat (D + 6) begin tick(); if (cpu_clk_en) np++; end
        mode_btn = 1'b0;
        repeat (D + 6) begin tick(); if (cpu_clk_en) np++; end
        check_val("halt_ignore", np, 0);
        check_val("halt_sticky", int'(halted), 1);
        do_reset();
        tick();
        check_val("post_reset_halted", int'(halted), 0);

        // Step and mode events in the same cycle: mode wins, no pulse.
        step_btn = 1'b1;
        mode_btn = 1'b1;
        wait_running("both_running");
        check_val("both_nopulse", int'(cpu_clk_en), 0);
        step_btn = 1'b0;
        mode_btn = 1'b0;
        repeat (12) tick();

        // Random activity against the model.
        do_reset();
        hold_cnt = 0;
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 29) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 59) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(0, 199) == 0) rate_sel = 2'($urandom_range(0, 3));
            halt = ($urandom_range(0, 999) == 0);
            tick();
            if (m_state == S_HALT) hold_cnt++;
            if (hold_cnt > 40) begin
                halt = 1'b0;
                do_reset();
                hold_cnt = 0;
            end
        end
        halt = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
